matmul_sequencer: RTL
=====================

Name: matmul_sequencer

Overview:
- Control FSM for the 3x3 matrix-multiply datapath.
- Once a start handshake is accepted, it walks C = A x B for dimensions n (rows of A), m (inner), p (columns of B).
- For each C element it issues row-major element indices into the A/B/C register banks, drives the MAC enables and pulses the C write strobe.
- It sits between the top-level command interface and the register file / MAC unit.

Parameters:
- MAXDIM, 3, maximum matrix dimension; banks hold MAXDIM*MAXDIM elements stored row-major.
- DIMW, 6, width of the n/m/p dimension inputs.
- IDXW, 4, width of flat element indices; must hold MAXDIM*MAXDIM-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE with no done.
- n_in, m_in, p_in  in  DIMW each  dimensions, latched when start is accepted.
- busy  out  1  high in MAC and WRITE states.
- done  out  1  one-cycle completion pulse.
- err  out  1  set when the last accepted start had invalid dimensions.
- a_idx, b_idx, c_idx  out  IDXW each  flat element indices.
- mac_en  out  1  MAC consumes A[a_idx]*B[b_idx] this cycle.
- mac_first  out  1  with mac_en: load the product and do not accumulate.
- c_we  out  1  write the MAC result into C[c_idx] this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; i, j, k, n_r, m_r, p_r and err are cleared.
  - Every output is 0 while reset is asserted and after reset releases.
- Reset mid-operation: the sequence is abandoned and no done is produced.
- States: IDLE, MAC, WRITE, DONE. All outputs decode from registered state and counters only; there is no combinational input-to-output path.
- IDLE:
  - On start=1, latch n/m/p and set i=j=k=0.
  - Dimensions are valid when each of n, m, p is in 1..MAXDIM.
  - Valid: err<=0, next state MAC.
  - Invalid: err<=1, next state DONE; no mac_en or c_we is ever issued.
- MAC:
  - mac_en=1, a_idx=i*MAXDIM+k, b_idx=k*MAXDIM+j, mac_first=(k==0).
  - If k==m_r-1, go to WRITE; otherwise k<=k+1.
- WRITE:
  - c_we=1, c_idx=i*MAXDIM+j; k<=0.
  - If j<p_r-1: j<=j+1, go to MAC.
  - Else if i<n_r-1: j<=0, i<=i+1, go to MAC.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. err holds its value until the next accepted start.
- Latency: n*p*(m+1) busy cycles, then the done cycle. The first mac_en appears in the cycle after start is sampled.
- start outside IDLE is ignored. start and done may coincide only via the next IDLE cycle.
- abort=1 in MAC or WRITE: next state IDLE, counters cleared, no done, no c_we. abort has priority over all transitions.
- abort in IDLE or DONE has no effect; DONE still completes. abort and start together in IDLE: abort wins and start is dropped.
- Index outputs read 0 whenever their strobe is low.
- Counters are 2 bits for MAXDIM=3, so wrap is impossible; index arithmetic is unsigned and truncated to IDXW.

Decomposition:
- Shared package matmul_pkg holds:
  - State encoding: IDLE=0, MAC=1, WRITE=2, DONE=3.
  - Constants MAXDIM, DIMW, IDXW.
  - An index function flat_idx(row, col) = row*MAXDIM + col.
- One natural sub-module, matmul_idx_counter: the nested i/j/k counter with wrap and last flags. The FSM consumes its last_k, last_j and last_i outputs.

Test Plan:
- n=m=p=2, start pulse:
  - a_idx sequence 0,1; b_idx sequence 0,3; then c_we with c_idx=0.
  - Full c_idx order is 0,1,3,4.
  - busy for 12 cycles; done in cycle 13; err=0.
- n=m=p=1: mac_en with mac_first=1 and a_idx=b_idx=0, then c_we with c_idx=0, then done; 3 cycles total.
- n=m=p=3: 36 busy cycles; last MAC has a_idx=8, b_idx=8; last c_we has c_idx=8; done next cycle.
- m_in=0 or p_in=4: done and err=1 in the second cycle after start; mac_en and c_we never asserted. A following valid start clears err.
- start re-pulsed mid-run: ignored, with an unchanged index sequence.
- abort during the second MAC cycle: IDLE next cycle, busy=0, no done.
- rst_n low mid-run: all outputs 0 immediately, without waiting for a clock edge.
- n=3, m=2, p=1: c_idx order 0,3,6; b_idx pattern 0,3 repeated.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply sequencer.
// It also provides the row-major flat index helper and the dimension range check.
package matmul_pkg;

  localparam int MAXDIM = 3;
  localparam int DIMW   = 6;
  localparam int IDXW   = 4;
  localparam int CNTW   = $clog2(MAXDIM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [IDXW-1:0] flat_idx(input logic [CNTW-1:0] row,
                                               input logic [CNTW-1:0] col);
    return IDXW'(row) * IDXW'(MAXDIM) + IDXW'(col);
  endfunction

  function automatic logic dim_ok(input logic [DIMW-1:0] d);
    return (d != '0) && (d <= DIMW'(MAXDIM));
  endfunction

endpackage

// File: rtl/matmul_idx_counter.sv
// Nested i/j/k loop counter for C = A x B.
// k is the inner index, j the column of C and i the row of C; last flags compare each against its dimension.
module matmul_idx_counter
  import matmul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            inc_k_i,
  input  logic            step_i,
  input  logic [DIMW-1:0] n_i,
  input  logic [DIMW-1:0] m_i,
  input  logic [DIMW-1:0] p_i,
  output logic [CNTW-1:0] i_o,
  output logic [CNTW-1:0] j_o,
  output logic [CNTW-1:0] k_o,
  output logic            last_i_o,
  output logic            last_j_o,
  output logic            last_k_o
);

  logic [CNTW-1:0] i_q, j_q, k_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (clr_i) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (inc_k_i) begin
      k_q <= k_q + CNTW'(1);
    end else if (step_i) begin
      k_q <= '0;
      if (!last_j_o) begin
        j_q <= j_q + CNTW'(1);
      end else if (!last_i_o) begin
        j_q <= '0;
        i_q <= i_q + CNTW'(1);
      end
    end
  end

  assign last_i_o = (DIMW'(i_q) == n_i - DIMW'(1));
  assign last_j_o = (DIMW'(j_q) == p_i - DIMW'(1));
  assign last_k_o = (DIMW'(k_q) == m_i - DIMW'(1));

  assign i_o = i_q;
  assign j_o = j_q;
  assign k_o = k_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM that walks C = A x B, issuing A/B/C bank indices, MAC enables and the C write strobe.
// Every output decodes from registered state and counters only.
module matmul_sequencer
  import matmul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [DIMW-1:0] n_in,
  input  logic [DIMW-1:0] m_in,
  input  logic [DIMW-1:0] p_in,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [IDXW-1:0] a_idx,
  output logic [IDXW-1:0] b_idx,
  output logic [IDXW-1:0] c_idx,
  output logic            mac_en,
  output logic            mac_first,
  output logic            c_we
);

  state_e          state_q, state_d;
  logic [DIMW-1:0] n_q, n_d, m_q, m_d, p_q, p_d;
  logic            err_q, err_d;
  logic            cnt_clr, cnt_inc_k, cnt_step;
  logic [CNTW-1:0] i_cnt, j_cnt, k_cnt;
  logic            last_i, last_j, last_k;

  matmul_idx_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr),
    .inc_k_i  (cnt_inc_k),
    .step_i   (cnt_step),
    .n_i      (n_q),
    .m_i      (m_q),
    .p_i      (p_q),
    .i_o      (i_cnt),
    .j_o      (j_cnt),
    .k_o      (k_cnt),
    .last_i_o (last_i),
    .last_j_o (last_j),
    .last_k_o (last_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_d       = m_q;
    p_d       = p_q;
    err_d     = err_q;
    cnt_clr   = 1'b0;
    cnt_inc_k = 1'b0;
    cnt_step  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          n_d     = n_in;
          m_d     = m_in;
          p_d     = p_in;
          cnt_clr = 1'b1;
          if (dim_ok(n_in) && dim_ok(m_in) && dim_ok(p_in)) begin
            err_d   = 1'b0;
            state_d = ST_MAC;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_MAC: begin
        if (abort) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (last_k) begin
          state_d = ST_WRITE;
        end else begin
          cnt_inc_k = 1'b1;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_step = 1'b1;
          state_d  = (last_j && last_i) ? ST_DONE : ST_MAC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mac_en    = (state_q == ST_MAC);
  assign c_we      = (state_q == ST_WRITE);
  assign busy      = mac_en || c_we;
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign mac_first = mac_en && (k_cnt == '0);
  // Indices are forced to zero whenever their strobe is low.
  assign a_idx     = mac_en ? flat_idx(i_cnt, k_cnt) : '0;
  assign b_idx     = mac_en ? flat_idx(k_cnt, j_cnt) : '0;
  assign c_idx     = c_we   ? flat_idx(i_cnt, j_cnt) : '0;

endmodule
